// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types and glyph table for the 7-segment display blocks.
//   seg7_t      - segment vector {a,b,c,d,e,f,g}, bit6 = a, active-low
//   SEG_OFF     - all segments dark
//   GLYPH_ROM   - 16-entry hex glyph table (0-9, A, b, C, d, E, F)
//   digit_glyph - nibble -> glyph lookup
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_OFF = 7'h7F;

  localparam seg7_t GLYPH_ROM [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,  // 0 1 2 3
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,  // 4 5 6 7
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,  // 8 9 A b
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000   // C d E F
  };

  function automatic seg7_t digit_glyph(input logic [3:0] nib);
    return GLYPH_ROM[nib];
  endfunction

endpackage

// File: rtl/hex_glyph_decode.sv
// hex_glyph_decode: combinational hex nibble to active-low 7-segment glyph.
//   nibble - 4-bit hex value
//   glyph  - {a..g}, bit6 = a, active-low
module hex_glyph_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] glyph
);

  assign glyph = digit_glyph(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for NUM_DIGITS common-anode digits.
//   clk, rst     - clock, synchronous active-high reset
//   value        - packed hex nibbles, nibble i = digit i
//   load         - capture value; it goes live at the next frame boundary
//   dp_in        - decimal point request per digit (1 = on)
//   blank_mask   - 1 forces a digit dark
//   lz_suppress  - blank leading zeros (digit 0 always shown)
//   blink_en     - blink the whole display every BLINK_FRAMES frames
//   seg, dp, an  - registered active-low pin drives
//   frame_done   - one-cycle pulse per frame boundary
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_suppress,
  input  logic                    blink_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = $clog2(BLINK_FRAMES + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0] presc;
  logic [IW-1:0] idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_ph;

  // active drives the pins; pending collects loads until the next frame
  // boundary so a frame never shows a mix of old and new digits.
  logic [NUM_DIGITS-1:0][3:0] active;
  logic [NUM_DIGITS-1:0][3:0] pending;
  logic                       pending_vld;

  logic slot_end, frame_end;
  assign slot_end  = (presc == PRESC_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // per-digit glyph decode and leading-zero chain
  logic [NUM_DIGITS-1:0][6:0] glyph;
  logic [NUM_DIGITS:1]        lz_chain;  // digits NUM_DIGITS-1..i all zero
  logic [NUM_DIGITS-1:0]      zsup;

  assign lz_chain[NUM_DIGITS] = 1'b1;

  genvar g;
  generate
    for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
      hex_glyph_decode u_dec (
        .nibble (active[g]),
        .glyph  (glyph[g])
      );
      if (g == 0) begin : g_lsd
        assign zsup[g] = 1'b0;
      end else begin : g_msd
        assign lz_chain[g] = lz_chain[g+1] && (active[g] == 4'h0);
        assign zsup[g]     = lz_chain[g];
      end
    end
  endgenerate

  // next pin state for the digit currently indexed
  logic                  cur_dark;
  logic [NUM_DIGITS-1:0] an_nxt;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;

  always_comb begin
    cur_dark = blank_mask[idx] | (blink_en & blink_ph) | (lz_suppress & zsup[idx]);
    an_nxt   = '1;
    seg_nxt  = SEG_OFF;
    dp_nxt   = 1'b1;
    if (!cur_dark) begin
      an_nxt[idx] = 1'b0;
      seg_nxt     = glyph[idx];
      dp_nxt      = ~dp_in[idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc       <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      blink_ph    <= 1'b0;
      active      <= '0;
      pending     <= '0;
      pending_vld <= 1'b0;
      an          <= '1;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      frame_done  <= 1'b0;
    end else begin
      presc <= slot_end ? '0 : presc + PW'(1);
      if (slot_end)
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);

      an         <= an_nxt;
      seg        <= seg_nxt;
      dp         <= dp_nxt;
      frame_done <= frame_end;

      if (frame_end) begin
        // a load landing on the boundary cycle bypasses pending
        if (load)             active <= value;
        else if (pending_vld) active <= pending;
        pending_vld <= 1'b0;
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end

      if (load) begin
        pending <= value;
        if (!frame_end) pending_vld <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed, table-driven bench for seg7_scan_driver
// (NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2).
module tb_seg7_scan_driver;

  localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010, G3 = 7'b0000110;
  localparam logic [6:0] G4 = 7'b1001100, G5 = 7'b0100100, G7 = 7'b0001111;
  localparam logic [6:0] G8 = 7'b0000000, GA = 7'b0001000;
  localparam logic [6:0] GC = 7'b0110001, GD = 7'b1000010, GE = 7'b0110000, GF = 7'b0111000;

  // expected frame: per slot lit flag, glyph and active-low dp (slot 3 in upper bits)
  typedef struct packed {
    logic [3:0]      lit;
    logic [3:0][6:0] seg;
    logic [3:0]      dpn;
  } frame_t;

  typedef struct {
    logic [15:0] value;
    logic        lz;
    logic [3:0]  blank;
    logic [3:0]  dpin;
    frame_t      exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic [3:0]  dp_in;
  logic [3:0]  blank_mask;
  logic        lz_suppress;
  logic        blink_en;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .value       (value),
    .load        (load),
    .dp_in       (dp_in),
    .blank_mask  (blank_mask),
    .lz_suppress (lz_suppress),
    .blink_en    (blink_en),
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_done  (frame_done)
  );

  task automatic chk(input string nm, input int k, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s k=%0d got an=%b seg=%b dp=%b fd=%b want an=%b seg=%b dp=%b fd=%b",
               nm, k, act[12:9], act[8:2], act[1], act[0], exp[12:9], exp[8:2], exp[1], exp[0]);
    end
  endtask

  // Checks 16 consecutive cycles starting one edge after the current negedge.
  // Optionally pulses load with ld_v after the compare at cycle ld_k.
  task automatic check_frame(input frame_t f, input int ld_k, input logic [15:0] ld_v, input string nm);
    logic [3:0] one;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    one = 4'b0001;
    for (int k = 0; k < 16; k++) begin
      int s;
      @(negedge clk);
      load = 1'b0;
      s = k / 4;
      e_an  = f.lit[s] ? ~(one << s) : 4'b1111;
      e_seg = f.lit[s] ? f.seg[s] : 7'h7F;
      e_dp  = f.lit[s] ? f.dpn[s] : 1'b1;
      chk(nm, k, {an, seg, dp, frame_done}, {e_an, e_seg, e_dp, (k == 15)});
      if (k == ld_k) begin
        load  = 1'b1;
        value = ld_v;
      end
    end
  endtask

  task automatic sync_frame(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      load = 1'b0;
      n++;
    end while (!frame_done && n < 40);
    if (!frame_done) begin
      checks++;
      failures++;
      $display("FAIL %s frame_done timeout after %0d cycles", nm, n);
    end
  endtask

  vec_t   tbl [7];
  frame_t f_zero, f_4000, f_ffff, f_1234, f_blit, f_dark;

  initial begin
    rst = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank_mask = '0;
    lz_suppress = 1'b0; blink_en = 1'b0;

    tbl[0] = '{16'h12AD, 1'b0, 4'b0000, 4'b0000, {4'b1111, {G1, G2, GA, GD}, 4'b1111}};
    tbl[1] = '{16'h0000, 1'b1, 4'b0000, 4'b0000, {4'b0001, {G0, G0, G0, G0}, 4'b1111}};
    tbl[2] = '{16'h0050, 1'b1, 4'b0000, 4'b0000, {4'b0011, {G0, G0, G5, G0}, 4'b1111}};
    tbl[3] = '{16'h12AD, 1'b0, 4'b0100, 4'b0001, {4'b1011, {G1, G2, GA, GD}, 4'b1110}};
    tbl[4] = '{16'h0F08, 1'b1, 4'b0000, 4'b0000, {4'b0111, {G0, GF, G0, G8}, 4'b1111}};
    tbl[5] = '{16'h3C7E, 1'b0, 4'b0000, 4'b1010, {4'b1111, {G3, GC, G7, GE}, 4'b0101}};
    tbl[6] = '{16'h4000, 1'b1, 4'b0000, 4'b0000, {4'b1111, {G4, G0, G0, G0}, 4'b1111}};

    f_zero = {4'b1111, {G0, G0, G0, G0}, 4'b1111};
    f_4000 = {4'b1111, {G4, G0, G0, G0}, 4'b1111};
    f_ffff = {4'b1111, {GF, GF, GF, GF}, 4'b1111};
    f_1234 = {4'b1111, {G1, G2, G3, G4}, 4'b1111};
    f_blit = {4'b1011, {G0, G0, G0, G0}, 4'b1110};
    f_dark = {4'b0000, {G0, G0, G0, G0}, 4'b1111};

    // reset state
    repeat (3) @(negedge clk);
    chk("reset", 0, {an, seg, dp, frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});

    // first frame after release shows zeros; a load inside it appears next frame
    rst = 1'b0;
    check_frame(f_zero, 0, 16'h12AD, "post_reset");
    check_frame(tbl[0].exp, -1, 16'h0, "first_load");

    // table: load, wait for the boundary that applies it, set live controls, check frame
    for (int i = 0; i < 7; i++) begin
      value = tbl[i].value;
      load  = 1'b1;
      sync_frame("sync");
      lz_suppress = tbl[i].lz;
      blank_mask  = tbl[i].blank;
      dp_in       = tbl[i].dpin;
      check_frame(tbl[i].exp, -1, 16'h0, $sformatf("vec%0d", i));
    end

    // mid-frame load is held off until the boundary; boundary-cycle load applies at once
    lz_suppress = 1'b0;
    check_frame(f_4000, 5, 16'hFFFF, "hold_old");
    check_frame(f_ffff, 14, 16'h1234, "new_value");
    check_frame(f_1234, -1, 16'h0, "boundary_load");

    // pending load, then a one-cycle reset mid-frame
    value = 16'h9999;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1; blink_en = 1'b1; blank_mask = 4'b0100; dp_in = 4'b0001;
    @(negedge clk);
    chk("mid_reset", 0, {an, seg, dp, frame_done}, {4'hF, 7'h7F, 1'b1, 1'b0});
    rst = 1'b0;

    // blink: lit 2 frames, dark 2, lit; pending 9999 must not appear
    check_frame(f_blit, -1, 16'h0, "blink_lit0");
    check_frame(f_blit, -1, 16'h0, "blink_lit1");
    check_frame(f_dark, -1, 16'h0, "blink_dark0");
    check_frame(f_dark, -1, 16'h0, "blink_dark1");
    check_frame(f_blit, -1, 16'h0, "blink_lit2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits sharing one segment bus.
- Takes a packed hex word and scans one digit per refresh slot.
- Adds frame-synchronous value update, leading-zero suppression, per-digit blanking, decimal points and whole-display blink.
- Sits between the CPU output register and the board display pins.
- Successor to the single-digit hex decoder. Full 0-F glyph set; 13 displays "d".

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
REFRESH_DIV, 50000, clk cycles each digit stays lit (>=2)
BLINK_FRAMES, 64, full scan frames per blink half-period (>=1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
value  input  4*NUM_DIGITS  hex nibbles; nibble i = digit i, digit 0 least significant
load  input  1  capture value into pending register this cycle
dp_in  input  NUM_DIGITS  decimal point request per digit, 1 = on
blank_mask  input  NUM_DIGITS  1 forces the digit dark
lz_suppress  input  1  enable leading-zero suppression
blink_en  input  1  enable whole-display blink
seg  output  7  segments {a,b,c,d,e,f,g}, bit6 = a, active-low
dp  output  1  decimal point, active-low
an  output  NUM_DIGITS  digit enables, active-low, at most one low
frame_done  output  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset is synchronous and active-high. While rst=1 at the clock edge:
  - an = all 1s, seg = 7'h7F, dp = 1, frame_done = 0.
  - prescaler = 0, digit index = 0, blink phase = 0, blink frame count = 0.
  - active = 0, pending = 0, pending_valid = 0.
- Reset mid-scan aborts the frame immediately. Any pending load is discarded.
- Prescaler counts 0..REFRESH_DIV-1. Its width is $clog2(REFRESH_DIV). At terminal count it wraps to 0 and the digit index advances; index NUM_DIGITS-1 wraps to 0.
- Frame boundary = index wrapping NUM_DIGITS-1 -> 0. On that edge:
  - frame_done pulses for exactly one cycle.
  - If pending_valid, active <= pending and pending_valid clears.
  - Blink frame count increments. On reaching BLINK_FRAMES it resets to 0 and blink phase toggles.
- load: pending <= value and pending_valid <= 1. The last load before a boundary wins.
- load on the same cycle as a boundary: that cycle's value becomes active at that boundary.
- Displayed data changes only at frame boundaries; no tearing within a frame.
- Outputs are registered with one cycle of latency from index/state to pins. After rst deasserts, digit 0 is driven on the first cycle.
- Digit i is dark (an[i] = 1, seg = 7'h7F, dp = 1) when any of the following holds:
  - blank_mask[i] = 1.
  - blink_en = 1 and blink phase = 1.
  - lz_suppress = 1, i != 0, and every active nibble from NUM_DIGITS-1 down to i is 0.
- Digit 0 is never zero-suppressed; a value of 0 shows a single "0".
- A dark digit still occupies its full time slot; scan timing never changes.
- When not dark: an has bit i low, seg = glyph(active nibble i), dp = ~dp_in[i].
- dp_in, blank_mask, lz_suppress and blink_en act live, sampled every cycle.
- blink_en = 0 forces a lit display but leaves blink phase and frame count running.
- Glyphs, active-low {a..g}:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0001100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000

Decomposition:
- Shared package seg7_pkg:
  - SEG_OFF = 7'h7F.
  - The 16-entry glyph constant array.
  - Function digit_glyph(nibble).
  - Typedef seg7_t (7-bit).
- One sub-module, hex_glyph_decode: combinational, nibble -> seg7_t, built on the package function.
- seg7_scan_driver holds:
  - prescaler, index and blink counters
  - pending/active registers
  - suppression logic
  - output registers

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2):
- Reset, then load value=16'h12AD, wait one frame -> an cycles 1110,1101,1011,0111, each held 4 cycles. seg shows d=1000010, A=0001000, 2=0010010, 1=1001111. frame_done pulses every 16 cycles.
- Load 16'h0000 with lz_suppress=1 -> only digit 0 lights with glyph 0. an = 1111 during slots 1-3.
- Load 16'h0050 with lz_suppress=1 -> digits 0 and 1 show 0 and 5; digits 2 and 3 are dark.
- Load 16'hFFFF mid-frame -> the old value is held until the next frame_done, then the new value appears. A load on the boundary cycle takes effect on that boundary.
- blink_en=1 -> display lit 2 frames, dark 2 frames, repeating. blank_mask=4'b0100 keeps digit 2 dark throughout. dp_in=4'b0001 drives dp=0 only in the digit-0 slot.
- Assert rst mid-frame for 1 cycle -> next cycle an=1111, seg=7F. Then digit 0 shows 0; the pre-reset pending load is lost.
